// File: rtl/lifo_pkg.sv
// Shared constants and helpers for the LIFO and its request arbiter.
//   LIFO_DWIDTH : default data word width of the LIFO and its arbiter
//   LIFO_AWIDTH : default LIFO address width (depth = 2**LIFO_AWIDTH)
//   ptr_width() : width of a round-robin pointer addressing n requesters
package lifo_pkg;

    localparam int LIFO_DWIDTH = 16;
    localparam int LIFO_AWIDTH = 4;

    // A pointer over n ports needs clog2(n) bits; never fewer than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin one-hot arbiter, purely combinational.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index where the search starts (current priority holder)
//   en_i      : 0 forces no grant (LIFO flag or reset blocks this side)
//   gnt_o     : one-hot grant (all zero when nothing wins)
//   ptr_nxt_o : winner+1 mod N after a grant, otherwise ptr_i unchanged
module rr_arb #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk the ports in ascending order starting at ptr_i, wrapping at N;
    // the first requester seen wins.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt_o  = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/lifo_arb.sv
// Shares one LIFO between N_PORTS requesters with independent round-robin
// push and pop arbitration.
//
// Handshake: a port raises wr_req_i / rd_req_i and holds it (and its push
// data) until the matching grant bit is high in the same cycle; the
// transfer happens at the rising edge where request and grant are both
// high. Dropping a request before a grant is allowed. A popped word shows
// up one cycle after its pop grant, marked by rd_valid_o for that port.
//
// Ports:
//   clk_i, srst_i         clock, synchronous active-low reset
//   wr_req_i / wr_gnt_o   per-port push request / one-hot push grant
//   wr_data_i             per-port push data, port k at [k*DWIDTH +: DWIDTH]
//   rd_req_i / rd_gnt_o   per-port pop request / one-hot pop grant
//   rd_valid_o, rd_data_o which port owns the popped word, and the word
//   lifo_*                connections to the shared LIFO
module lifo_arb
    import lifo_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DWIDTH  = LIFO_DWIDTH
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic [N_PORTS-1:0]          wr_req_i,
    input  logic [N_PORTS*DWIDTH-1:0]   wr_data_i,
    output logic [N_PORTS-1:0]          wr_gnt_o,
    input  logic [N_PORTS-1:0]          rd_req_i,
    output logic [N_PORTS-1:0]          rd_gnt_o,
    output logic [N_PORTS-1:0]          rd_valid_o,
    output logic [DWIDTH-1:0]           rd_data_o,
    output logic                        lifo_wrreq_o,
    output logic [DWIDTH-1:0]           lifo_data_o,
    output logic                        lifo_rdreq_o,
    input  logic [DWIDTH-1:0]           lifo_q_i,
    input  logic                        lifo_full_i,
    input  logic                        lifo_empty_i
);

    localparam int PW = ptr_width(N_PORTS);

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [N_PORTS-1:0] rd_valid_q, rd_valid_d;
    logic               wr_en, rd_en;

    // Reset low kills both grant paths combinationally.
    assign wr_en = srst_i & ~lifo_full_i;
    assign rd_en = srst_i & ~lifo_empty_i;

    rr_arb #(.N(N_PORTS), .PW(PW)) u_wr_arb (
        .req_i     (wr_req_i),
        .ptr_i     (wr_ptr_q),
        .en_i      (wr_en),
        .gnt_o     (wr_gnt_o),
        .ptr_nxt_o (wr_ptr_d)
    );

    rr_arb #(.N(N_PORTS), .PW(PW)) u_rd_arb (
        .req_i     (rd_req_i),
        .ptr_i     (rd_ptr_q),
        .en_i      (rd_en),
        .gnt_o     (rd_gnt_o),
        .ptr_nxt_o (rd_ptr_d)
    );

    always_comb begin
        rd_valid_d  = rd_gnt_o;
        lifo_data_o = '0;
        // Grant is one-hot, so OR-ing the gated slices is a clean mux.
        for (int k = 0; k < N_PORTS; k++) begin
            if (wr_gnt_o[k]) begin
                lifo_data_o = lifo_data_o | wr_data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign lifo_wrreq_o = |wr_gnt_o;
    assign lifo_rdreq_o = |rd_gnt_o;

    // The LIFO is reset by the same net, so a word popped just before a
    // reset is lost; masking here keeps that pending valid from escaping.
    assign rd_valid_o = srst_i ? rd_valid_q : '0;
    assign rd_data_o  = (|rd_valid_o) ? lifo_q_i : '0;

endmodule

// File: tb/tb_lifo_arb.sv
module tb_lifo_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            srst;
    logic [N-1:0]    wr_req, rd_req;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    wr_gnt_o, rd_gnt_o, rd_valid_o;
    logic [DW-1:0]   rd_data_o, lifo_data_o, lifo_q;
    logic            lifo_wrreq_o, lifo_rdreq_o;
    logic            force_full;
    logic            lifo_full, lifo_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    lifo_arb #(.N_PORTS(N), .DWIDTH(DW)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .wr_req_i     (wr_req),
        .wr_data_i    (wr_data),
        .wr_gnt_o     (wr_gnt_o),
        .rd_req_i     (rd_req),
        .rd_gnt_o     (rd_gnt_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .lifo_wrreq_o (lifo_wrreq_o),
        .lifo_data_o  (lifo_data_o),
        .lifo_rdreq_o (lifo_rdreq_o),
        .lifo_q_i     (lifo_q),
        .lifo_full_i  (lifo_full),
        .lifo_empty_i (lifo_empty)
    );

    // ---------------- behavioural LIFO (stimulus side) ----------------
    // One-cycle read latency; on push+pop the old top is returned and the
    // new word replaces it.
    logic [DW-1:0] mem [DEPTH];
    int            sp;

    assign lifo_full  = (sp == DEPTH) | force_full;
    assign lifo_empty = (sp == 0);

    always @(posedge clk) begin
        if (!srst) begin
            sp <= 0;
        end else if (lifo_rdreq_o && sp > 0) begin
            lifo_q <= mem[sp-1];
            if (lifo_wrreq_o) mem[sp-1] <= lifo_data_o;
            else              sp <= sp - 1;
        end else if (lifo_wrreq_o && sp < DEPTH) begin
            mem[sp] <= lifo_data_o;
            sp      <= sp + 1;
        end
    end

    // ---------------- scoreboard helpers ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_stk[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are set by the caller just after a falling edge; outputs are
    // checked 1 ns later and the cycle then commits at the rising edge.
    task automatic expect_cycle(input string tag, input logic [N-1:0] e_wg,
                                input logic [N-1:0] e_rg, input logic [DW-1:0] e_ld,
                                input logic [N-1:0] e_rv, input logic [DW-1:0] e_rd);
        #1;
        chk({tag, "/wr_gnt"},     wr_gnt_o,     e_wg);
        chk({tag, "/lifo_wrreq"}, lifo_wrreq_o, |e_wg);
        chk({tag, "/lifo_data"},  lifo_data_o,  e_ld);
        chk({tag, "/rd_gnt"},     rd_gnt_o,     e_rg);
        chk({tag, "/lifo_rdreq"}, lifo_rdreq_o, |e_rg);
        chk({tag, "/rd_valid"},   rd_valid_o,   e_rv);
        if (e_rv != '0) chk({tag, "/rd_data"}, rd_data_o, e_rd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b0; wr_req = '0; rd_req = '0; wr_data = '0; force_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  wr_req;
        logic [N-1:0]  rd_req;
        logic [N-1:0]  e_wg;
        logic [N-1:0]  e_rg;
        logic [DW-1:0] e_ld;
        logic [N-1:0]  e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl [15];

    // random-phase state
    logic [N-1:0]  wpend, rpend, exp_rv;
    logic [DW-1:0] wdat [N];
    int            wwait [N];
    int            rwait [N];
    int            max_wwait, max_rwait;

    initial begin
        // ---- reset behaviour: grants masked with requests present ----
        do_reset();
        srst = 1'b0; wr_req = 4'hF; rd_req = 4'hF; wr_data = 64'h0013_0012_0011_0010;
        expect_cycle("reset_mask", 4'h0, 4'h0, 16'h0, 4'h0, 16'h0);
        srst = 1'b1; wr_req = '0; rd_req = '0;

        // ---- table: fill to full with all ports, then pops and mixes ----
        tbl[0]  = '{4'hF, 4'h0, 4'h1, 4'h0, 16'h10, 4'h0, 16'h0};
        tbl[1]  = '{4'hF, 4'h0, 4'h2, 4'h0, 16'h11, 4'h0, 16'h0};
        tbl[2]  = '{4'hF, 4'h0, 4'h4, 4'h0, 16'h12, 4'h0, 16'h0};
        tbl[3]  = '{4'hF, 4'h0, 4'h8, 4'h0, 16'h13, 4'h0, 16'h0};
        tbl[4]  = '{4'hF, 4'h0, 4'h1, 4'h0, 16'h10, 4'h0, 16'h0};
        tbl[5]  = '{4'hF, 4'h0, 4'h2, 4'h0, 16'h11, 4'h0, 16'h0};
        tbl[6]  = '{4'hF, 4'h0, 4'h4, 4'h0, 16'h12, 4'h0, 16'h0};
        tbl[7]  = '{4'hF, 4'h0, 4'h8, 4'h0, 16'h13, 4'h0, 16'h0};
        tbl[8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 16'h00, 4'h0, 16'h0};   // full
        tbl[9]  = '{4'h0, 4'hA, 4'h0, 4'h2, 16'h00, 4'h0, 16'h0};
        tbl[10] = '{4'h0, 4'hA, 4'h0, 4'h8, 16'h00, 4'h2, 16'h13};
        tbl[11] = '{4'h0, 4'hA, 4'h0, 4'h2, 16'h00, 4'h8, 16'h12};
        tbl[12] = '{4'h1, 4'h0, 4'h1, 4'h0, 16'h10, 4'h2, 16'h11};
        tbl[13] = '{4'h0, 4'h4, 4'h0, 4'h4, 16'h00, 4'h0, 16'h0};
        tbl[14] = '{4'h0, 4'h0, 4'h0, 4'h0, 16'h00, 4'h4, 16'h10};
        do_reset();
        wr_data = 64'h0013_0012_0011_0010;
        for (int i = 0; i < 15; i++) begin
            wr_req = tbl[i].wr_req;
            rd_req = tbl[i].rd_req;
            expect_cycle($sformatf("tbl%0d", i), tbl[i].e_wg, tbl[i].e_rg,
                         tbl[i].e_ld, tbl[i].e_rv, tbl[i].e_rd);
        end

        // ---- ports 1 and 3 pop four words in LIFO order ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_req = 4'h1;
            wr_data = '0;
            wr_data[0 +: DW] = 16'hA0 + 16'(i);
            expect_cycle($sformatf("pop4_push%0d", i), 4'h1, 4'h0, 16'hA0 + 16'(i), 4'h0, 16'h0);
        end
        wr_req = '0; rd_req = 4'hA;
        expect_cycle("pop4_a", 4'h0, 4'h2, 16'h0, 4'h0, 16'h0);
        expect_cycle("pop4_b", 4'h0, 4'h8, 16'h0, 4'h2, 16'hA3);
        expect_cycle("pop4_c", 4'h0, 4'h2, 16'h0, 4'h8, 16'hA2);
        expect_cycle("pop4_d", 4'h0, 4'h8, 16'h0, 4'h2, 16'hA1);
        expect_cycle("pop4_empty", 4'h0, 4'h0, 16'h0, 4'h8, 16'hA0);
        rd_req = '0;
        expect_cycle("pop4_idle", 4'h0, 4'h0, 16'h0, 4'h0, 16'h0);

        // ---- full blocks push, pop still granted, wr_ptr holds ----
        do_reset();
        wr_data = 64'h0000_0022_0000_0077;
        wr_req = 4'h1;
        expect_cycle("full_pre", 4'h1, 4'h0, 16'h77, 4'h0, 16'h0);
        force_full = 1'b1; wr_req = 4'b0101; rd_req = 4'h1;
        expect_cycle("full_block", 4'h0, 4'h1, 16'h0, 4'h0, 16'h0);
        force_full = 1'b0; rd_req = '0;
        expect_cycle("full_drop", 4'h4, 4'h0, 16'h22, 4'h1, 16'h77);

        // ---- empty blocks pop, push granted, pop follows ----
        do_reset();
        wr_data = 64'h0055_0000_0000_0000;
        wr_req = 4'h8; rd_req = 4'h2;
        expect_cycle("empty_block", 4'h8, 4'h0, 16'h55, 4'h0, 16'h0);
        wr_req = '0;
        expect_cycle("empty_pop", 4'h0, 4'h2, 16'h0, 4'h0, 16'h0);
        rd_req = '0;
        expect_cycle("empty_data", 4'h0, 4'h0, 16'h0, 4'h2, 16'h55);

        // ---- reset right after a pop grant ----
        do_reset();
        wr_req = 4'h1; wr_data = 64'h0000_0000_0000_0033;
        expect_cycle("rstpop_w0", 4'h1, 4'h0, 16'h33, 4'h0, 16'h0);
        wr_data = 64'h0000_0000_0000_0044;
        expect_cycle("rstpop_w1", 4'h1, 4'h0, 16'h44, 4'h0, 16'h0);
        wr_req = '0; rd_req = 4'hC;
        expect_cycle("rstpop_pop", 4'h0, 4'h4, 16'h0, 4'h0, 16'h0);
        srst = 1'b0; wr_req = 4'h9; wr_data = 64'h0099_0000_0000_0066;
        expect_cycle("rstpop_rst", 4'h0, 4'h0, 16'h0, 4'h0, 16'h0);
        srst = 1'b1;
        expect_cycle("rstpop_wlow", 4'h1, 4'h0, 16'h66, 4'h0, 16'h0);
        wr_req = '0;
        expect_cycle("rstpop_rlow", 4'h0, 4'h4, 16'h0, 4'h0, 16'h0);
        rd_req = 4'h8;
        expect_cycle("rstpop_data", 4'h0, 4'h0, 16'h0, 4'h4, 16'h66);
        rd_req = '0;

        // ---- random traffic against a reference stack ----
        do_reset();
        wpend = '0; rpend = '0; exp_rv = '0;
        max_wwait = 0; max_rwait = 0;
        exp_q.delete();
        ref_stk.delete();
        for (int k = 0; k < N; k++) begin
            wwait[k] = 0; rwait[k] = 0; wdat[k] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!wpend[k] && $urandom_range(0, 2) == 0) begin
                    wpend[k] = 1'b1;
                    wdat[k]  = 16'($urandom);
                end
                if (!rpend[k] && $urandom_range(0, 2) == 0) rpend[k] = 1'b1;
                wr_data[k*DW +: DW] = wdat[k];
            end
            wr_req = wpend;
            rd_req = rpend;
            #1;
            chk("rnd_wr_onehot", 32'($onehot0(wr_gnt_o)), 32'd1);
            chk("rnd_rd_onehot", 32'($onehot0(rd_gnt_o)), 32'd1);
            chk("rnd_wr_subset", wr_gnt_o & ~wpend, 4'h0);
            chk("rnd_rd_subset", rd_gnt_o & ~rpend, 4'h0);
            if (lifo_full)  chk("rnd_full_block",  wr_gnt_o, 4'h0);
            if (lifo_empty) chk("rnd_empty_block", rd_gnt_o, 4'h0);
            chk("rnd_rd_valid", rd_valid_o, exp_rv);
            if (exp_rv != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_rd_underflow", 32'd1, 32'd0);
                end else begin
                    chk("rnd_rd_data", rd_data_o, exp_q.pop_front());
                end
            end
            if (rd_gnt_o != '0) begin
                if (ref_stk.size() == 0) chk("rnd_pop_empty", 32'd1, 32'd0);
                else begin
                    exp_q.push_back(ref_stk[$]);
                    void'(ref_stk.pop_back());
                end
            end
            for (int k = 0; k < N; k++) begin
                if (wr_gnt_o[k]) begin
                    chk("rnd_lifo_data", lifo_data_o, wdat[k]);
                    ref_stk.push_back(wdat[k]);
                    wpend[k] = 1'b0; wwait[k] = 0;
                end else if (wpend[k] && !lifo_full) begin
                    wwait[k]++;
                    if (wwait[k] > max_wwait) max_wwait = wwait[k];
                end
                if (rd_gnt_o[k]) begin
                    rpend[k] = 1'b0; rwait[k] = 0;
                end else if (rpend[k] && !lifo_empty) begin
                    rwait[k]++;
                    if (rwait[k] > max_rwait) max_rwait = rwait[k];
                end
            end
            exp_rv = rd_gnt_o;
            @(posedge clk);
            @(negedge clk);
        end
        wr_req = '0; rd_req = '0;
        #1;
        chk("rnd_last_valid", rd_valid_o, exp_rv);
        if (exp_rv != '0 && exp_q.size() != 0) chk("rnd_last_data", rd_data_o, exp_q.pop_front());
        chk("rnd_exp_q_drained", exp_q.size(), 32'd0);
        chk("rnd_wr_fair", (max_wwait < N) ? 32'd1 : 32'd0, 32'd1);
        chk("rnd_rd_fair", (max_rwait < N) ? 32'd1 : 32'd0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
